// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock datapath: count directions and standard stage moduli.
package clock_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MOD_SEC   = 60;
    localparam int MOD_HOUR  = 24;
    localparam int MOD_DIGIT = 10;
    localparam int MOD_TENS  = 6;

endpackage

// File: rtl/bin2bcd8.sv
// Combinational binary-to-BCD converter for values 0..99, shared with the display path.
module bin2bcd8 (
    input  logic [6:0] i_bin,
    output logic [7:0] o_bcd
);

    assign o_bcd = {4'(i_bin / 7'd10), 4'(i_bin % 7'd10)};

endmodule

// File: rtl/mod_counter.sv
// Modulo-MOD digit stage: clamped synchronous load, BCD view, same-cycle carry for synchronous chaining.
// Down-count and borrow logic is compiled in only when MOD_COUNTER_DOWN_EN is defined.
module mod_counter
    import clock_pkg::*;
#(
    parameter int MOD   = 6,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [7:0]       bcd,
    output logic             carry_out
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_stepUp;
    logic [WIDTH-1:0] w_loadVal;
    logic [WIDTH:0]   w_inc;
    logic             w_atMax;
    logic             w_terminal;
    logic [6:0]       w_bin;

    // Step computed one bit wider so the wrap decision is made before writeback.
    assign w_inc     = {1'b0, r_count} + (WIDTH+1)'(1);
    assign w_atMax   = (w_inc == MOD_W);
    assign w_stepUp  = (w_inc >= MOD_W) ? '0 : w_inc[WIDTH-1:0];
    assign w_loadVal = ({1'b0, load_val} < MOD_W) ? load_val : MAX_VAL;

`ifdef MOD_COUNTER_DOWN_EN
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_stepDown;
    logic             w_atZero;
    logic             w_up;

    // Borrow out of the extra bit marks the 0 -> MOD-1 wrap.
    assign w_dec      = {1'b0, r_count} - (WIDTH+1)'(1);
    assign w_atZero   = w_dec[WIDTH];
    assign w_stepDown = w_atZero ? MAX_VAL : w_dec[WIDTH-1:0];
    assign w_up       = (dir == DIR_UP);
    assign w_terminal = w_up ? w_atMax : w_atZero;

    always_comb begin
        w_next = r_count;
        if (load) begin
            w_next = w_loadVal;
        end else if (en) begin
            w_next = w_up ? w_stepUp : w_stepDown;
        end
    end
`else
    logic w_unusedDir;

    assign w_unusedDir = dir;
    assign w_terminal  = w_atMax;

    always_comb begin
        w_next = r_count;
        if (load) begin
            w_next = w_loadVal;
        end else if (en) begin
            w_next = w_stepUp;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count     = r_count;
    assign carry_out = en & ~load & w_terminal;
    assign w_bin     = 7'(r_count);

    bin2bcd8 u_bin2bcd8 (
        .i_bin (w_bin),
        .o_bcd (bcd)
    );

endmodule
